// File: rtl/noc_arb_pkg.sv
// Shared types and helpers for the NoC output-port arbiter.
// Width helpers keep every derived field at least one bit wide.
package noc_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int idw_f(input int n);
    return clog2_min1(n);
  endfunction

  function automatic int pw_f(input int npri);
    return clog2_min1(npri);
  endfunction

  function automatic int cnt_w_f(input int lock_max);
    return clog2_min1(lock_max + 1);
  endfunction

  // Wrap by explicit compare so N need not be a power of two.
  function automatic int inc_mod(input int v, input int n);
    return (v == n - 1) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/noc_rr_lock_arb_rr_pick.sv
// Round-robin pick: first set bit of cand at or after ptr, modulo N.
// Rotates a doubled copy of the mask, then priority-encodes the low N bits.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   cand,
  input  logic [IDW-1:0] ptr,
  output logic           found,
  output logic [IDW-1:0] winner
);

  localparam logic [IDW:0] N_W = (IDW + 1)'(N);

  logic [N-1:0] rot_s;
  logic [IDW:0] off_s;
  logic [IDW:0] sum_s;

  // Rotate so bit 0 is the candidate at ptr, then take the lowest set bit.
  always_comb begin
    rot_s = N'({cand, cand} >> ptr);
    found = 1'b0;
    off_s = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot_s[k]) begin
        found = 1'b1;
        off_s = (IDW + 1)'(k);
      end else begin
        off_s = off_s;
      end
    end
    sum_s  = {1'b0, ptr} + off_s;
    winner = (sum_s >= N_W) ? IDW'(sum_s - N_W) : IDW'(sum_s);
  end

endmodule

// File: rtl/noc_rr_lock_arb.sv
// N-requester priority / round-robin arbiter with per-requester packet lock
// and optional lock-length cap; grant outputs are registered.
module noc_rr_lock_arb
  import noc_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int NPRI     = 2,
  parameter int LOCK_MAX = 0,
  localparam int PW      = pw_f(NPRI),
  localparam int IDW     = idw_f(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [N*PW-1:0] req_pri,
  input  logic [N-1:0]    lock,
  input  logic            out_ready,
  output logic [N-1:0]    grant,
  output logic            grant_valid,
  output logic [IDW-1:0]  grant_id
);

  localparam int            CW      = cnt_w_f(LOCK_MAX);
  localparam logic [PW-1:0] PRI_TOP = PW'(NPRI - 1);
  localparam logic [N-1:0]  ONE_N   = {{(N - 1){1'b0}}, 1'b1};

  arb_state_e     state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic           grant_valid_q, grant_valid_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  lock_cnt_q, lock_cnt_d;

  logic           req_g_s, lock_g_s, cap_hit_s;
  logic           rel_s, keep_s, excl_s, arb_s;
  logic [IDW-1:0] ptr_arb_s;
  logic [N-1:0]   mask_s, cand_s;
  logic [PW-1:0]  pri_s [N];
  logic [PW-1:0]  top_s;
  logic           found_s;
  logic [IDW-1:0] win_s;

  // Decide what the current grant does this cycle: hold, keep under lock, or release.
  always_comb begin
    req_g_s   = |(req & grant_q);
    lock_g_s  = |(lock & grant_q);
    cap_hit_s = (LOCK_MAX != 0) && (int'(lock_cnt_q) == LOCK_MAX - 1);
    rel_s     = 1'b0;
    keep_s    = 1'b0;
    excl_s    = 1'b0;
    case (state_q)
      IDLE: rel_s = 1'b0;
      GRANT: begin
        if (!req_g_s) begin
          rel_s = 1'b1;
        end else if (out_ready) begin
          if (lock_g_s && !cap_hit_s) begin
            keep_s = 1'b1;
          end else begin
            rel_s  = 1'b1;
            excl_s = lock_g_s;  // only a cap-forced holder sits out this round
          end
        end else begin
          rel_s = 1'b0;
        end
      end
      default: rel_s = 1'b0;
    endcase
    arb_s     = (state_q == IDLE) || rel_s;
    ptr_arb_s = rel_s ? IDW'(inc_mod(int'(grant_id_q), N)) : ptr_q;
    mask_s    = req & ~(excl_s ? grant_q : '0);
  end

  // Keep only the requests at the highest priority level present.
  always_comb begin
    top_s  = '0;
    cand_s = '0;
    for (int i = 0; i < N; i++) begin
      pri_s[i] = (req_pri[i*PW +: PW] > PRI_TOP) ? PRI_TOP : req_pri[i*PW +: PW];
      if (mask_s[i] && (pri_s[i] > top_s)) begin
        top_s = pri_s[i];
      end else begin
        top_s = top_s;
      end
    end
    for (int i = 0; i < N; i++) begin
      cand_s[i] = mask_s[i] && (pri_s[i] == top_s);
    end
  end

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .cand   (cand_s),
    .ptr    (ptr_arb_s),
    .found  (found_s),
    .winner (win_s)
  );

  // Next-state: re-arbitrate on idle or release, count locked transfers otherwise.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    ptr_d         = ptr_q;
    lock_cnt_d    = lock_cnt_q;
    if (arb_s) begin
      ptr_d      = ptr_arb_s;
      lock_cnt_d = '0;
      if (found_s) begin
        state_d       = GRANT;
        grant_d       = ONE_N << win_s;
        grant_valid_d = 1'b1;
        grant_id_d    = win_s;
      end else begin
        state_d       = IDLE;
        grant_d       = '0;
        grant_valid_d = 1'b0;
        grant_id_d    = '0;
      end
    end else if (keep_s && (LOCK_MAX != 0)) begin
      lock_cnt_d = lock_cnt_q + CW'(1);
    end else begin
      lock_cnt_d = lock_cnt_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      ptr_q         <= '0;
      lock_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      ptr_q         <= ptr_d;
      lock_cnt_q    <= lock_cnt_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_noc_rr_lock_arb.sv
// Scoreboard bench for noc_rr_lock_arb: three configurations driven one at a
// time with directed vectors; a monitor pops expected grants after each edge.
module tb_noc_rr_lock_arb;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // u0: N=4 NPRI=2 unlimited lock; u1: N=4 LOCK_MAX=2; u2: N=5
  logic [3:0] req0 = 4'b0, pri0 = 4'b0, lock0 = 4'b0, grant0;
  logic [3:0] req1 = 4'b0, pri1 = 4'b0, lock1 = 4'b0, grant1;
  logic [4:0] req2 = 5'b0, pri2 = 5'b0, lock2 = 5'b0, grant2;
  logic rdy0 = 1'b0, rdy1 = 1'b0, rdy2 = 1'b0;
  logic gv0, gv1, gv2;
  logic [1:0] gid0, gid1;
  logic [2:0] gid2;

  noc_rr_lock_arb #(.N(4), .NPRI(2), .LOCK_MAX(0)) u0 (
    .clk(clk), .reset(reset), .req(req0), .req_pri(pri0), .lock(lock0),
    .out_ready(rdy0), .grant(grant0), .grant_valid(gv0), .grant_id(gid0));
  noc_rr_lock_arb #(.N(4), .NPRI(2), .LOCK_MAX(2)) u1 (
    .clk(clk), .reset(reset), .req(req1), .req_pri(pri1), .lock(lock1),
    .out_ready(rdy1), .grant(grant1), .grant_valid(gv1), .grant_id(gid1));
  noc_rr_lock_arb #(.N(5), .NPRI(2), .LOCK_MAX(0)) u2 (
    .clk(clk), .reset(reset), .req(req2), .req_pri(pri2), .lock(lock2),
    .out_ready(rdy2), .grant(grant2), .grant_valid(gv2), .grant_id(gid2));

  typedef struct {
    int    sel;
    logic  v;
    int    id;
    string nm;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic step(input int sel, input logic [4:0] r, input logic [4:0] p,
                      input logic [4:0] l, input logic rdy, input logic rst,
                      input logic ev, input int eid, input string nm);
    exp_t e;
    @(negedge clk);
    reset = rst;
    req0  = (sel == 0) ? r[3:0] : 4'b0;
    pri0  = (sel == 0) ? p[3:0] : 4'b0;
    lock0 = (sel == 0) ? l[3:0] : 4'b0;
    rdy0  = (sel == 0) ? rdy : 1'b0;
    req1  = (sel == 1) ? r[3:0] : 4'b0;
    pri1  = (sel == 1) ? p[3:0] : 4'b0;
    lock1 = (sel == 1) ? l[3:0] : 4'b0;
    rdy1  = (sel == 1) ? rdy : 1'b0;
    req2  = (sel == 2) ? r : 5'b0;
    pri2  = (sel == 2) ? p : 5'b0;
    lock2 = (sel == 2) ? l : 5'b0;
    rdy2  = (sel == 2) ? rdy : 1'b0;
    e.sel = sel;
    e.v   = ev;
    e.id  = eid;
    e.nm  = nm;
    sb.push_back(e);
  endtask

  // Monitor: one expected entry per clock edge, checked just after the edge.
  initial begin
    exp_t e;
    logic av;
    int aid;
    logic [4:0] ag, eg;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.sel)
          0: begin av = gv0; aid = int'(gid0); ag = {1'b0, grant0}; end
          1: begin av = gv1; aid = int'(gid1); ag = {1'b0, grant1}; end
          default: begin av = gv2; aid = int'(gid2); ag = grant2; end
        endcase
        eg = e.v ? (5'b00001 << e.id) : 5'b00000;
        n_vec++;
        if (av !== e.v || aid != e.id || ag !== eg) begin
          n_err++;
          $display("FAIL %s: got valid=%0b id=%0d grant=%b, want valid=%0b id=%0d grant=%b",
                   e.nm, av, aid, ag, e.v, e.id, eg);
        end
      end
    end
  end

  initial begin
    // reset state of each configuration
    step(0, 5'b00000, 5'b00000, 5'b00000, 1'b0, 1'b1, 1'b0, 0, "rst_u0");
    step(1, 5'b00000, 5'b00000, 5'b00000, 1'b0, 1'b1, 1'b0, 0, "rst_u1");
    step(2, 5'b00000, 5'b00000, 5'b00000, 1'b0, 1'b1, 1'b0, 0, "rst_u2");

    // plain round robin across all four
    step(0, 5'b01111, 5'b00000, 5'b00000, 1'b1, 1'b0, 1'b1, 0, "rr0");
    step(0, 5'b01111, 5'b00000, 5'b00000, 1'b1, 1'b0, 1'b1, 1, "rr1");
    step(0, 5'b01111, 5'b00000, 5'b00000, 1'b1, 1'b0, 1'b1, 2, "rr2");
    step(0, 5'b01111, 5'b00000, 5'b00000, 1'b1, 1'b0, 1'b1, 3, "rr3");
    step(0, 5'b01111, 5'b00000, 5'b00000, 1'b1, 1'b0, 1'b1, 0, "rr_wrap");

    // requester 1 at higher priority keeps winning; drops -> requester 0
    step(0, 5'b00011, 5'b00010, 5'b00000, 1'b1, 1'b0, 1'b1, 1, "pri_a");
    step(0, 5'b00011, 5'b00010, 5'b00000, 1'b1, 1'b0, 1'b1, 1, "pri_b");
    step(0, 5'b00011, 5'b00010, 5'b00000, 1'b1, 1'b0, 1'b1, 1, "pri_c");
    step(0, 5'b00001, 5'b00010, 5'b00000, 1'b1, 1'b0, 1'b1, 0, "pri_drop");

    // requester 0 locked for three transfers, releases on the fourth
    step(0, 5'b00011, 5'b00000, 5'b00001, 1'b1, 1'b0, 1'b1, 0, "lock_a");
    step(0, 5'b00011, 5'b00000, 5'b00001, 1'b1, 1'b0, 1'b1, 0, "lock_b");
    step(0, 5'b00011, 5'b00000, 5'b00001, 1'b1, 1'b0, 1'b1, 0, "lock_c");
    step(0, 5'b00011, 5'b00000, 5'b00000, 1'b1, 1'b0, 1'b1, 1, "lock_rel");

    // stall on requester 2 while higher-priority requester 3 waits
    step(0, 5'b00100, 5'b00000, 5'b00000, 1'b1, 1'b0, 1'b1, 2, "stall_setup");
    for (int i = 0; i < 5; i++)
      step(0, 5'b01100, 5'b01000, 5'b00000, 1'b0, 1'b0, 1'b1, 2, "stall_hold");
    step(0, 5'b01100, 5'b01000, 5'b00000, 1'b1, 1'b0, 1'b1, 3, "stall_rel");
    step(0, 5'b00000, 5'b00000, 5'b00000, 1'b1, 1'b0, 1'b0, 0, "to_idle");
    step(0, 5'b00000, 5'b00000, 5'b00000, 1'b1, 1'b0, 1'b0, 0, "stay_idle");

    // lock cap of two transfers forces requester 0 out
    step(1, 5'b00101, 5'b00000, 5'b00001, 1'b1, 1'b0, 1'b1, 0, "cap_grant");
    step(1, 5'b00101, 5'b00000, 5'b00001, 1'b1, 1'b0, 1'b1, 0, "cap_keep");
    step(1, 5'b00101, 5'b00000, 5'b00001, 1'b1, 1'b0, 1'b1, 2, "cap_forced");
    step(1, 5'b00101, 5'b00000, 5'b00001, 1'b1, 1'b0, 1'b1, 0, "cap_rewin");
    step(1, 5'b00000, 5'b00000, 5'b00000, 1'b1, 1'b0, 1'b0, 0, "cap_idle");
    step(1, 5'b00001, 5'b00000, 5'b00001, 1'b1, 1'b0, 1'b1, 0, "solo_grant");
    step(1, 5'b00001, 5'b00000, 5'b00001, 1'b1, 1'b0, 1'b1, 0, "solo_keep");
    step(1, 5'b00001, 5'b00000, 5'b00001, 1'b1, 1'b0, 1'b0, 0, "solo_forced");
    step(1, 5'b00001, 5'b00000, 5'b00001, 1'b1, 1'b0, 1'b1, 0, "solo_again");
    step(1, 5'b00000, 5'b00000, 5'b00000, 1'b1, 1'b0, 1'b0, 0, "solo_idle");

    // N=5 wrap from requester 4, then reset in the middle of a lock
    step(2, 5'b10000, 5'b00000, 5'b00000, 1'b1, 1'b0, 1'b1, 4, "n5_r4");
    step(2, 5'b10001, 5'b00000, 5'b00000, 1'b1, 1'b0, 1'b1, 0, "n5_wrap");
    step(2, 5'b10001, 5'b00000, 5'b00000, 1'b1, 1'b0, 1'b1, 4, "n5_next");
    step(2, 5'b10001, 5'b00000, 5'b10000, 1'b1, 1'b0, 1'b1, 4, "n5_lock");
    step(2, 5'b10001, 5'b00000, 5'b10000, 1'b1, 1'b1, 1'b0, 0, "n5_reset");
    step(2, 5'b10001, 5'b00000, 5'b00000, 1'b1, 1'b0, 1'b1, 0, "n5_ptr0");
    step(2, 5'b00000, 5'b00000, 5'b00000, 1'b1, 1'b0, 1'b0, 0, "n5_idle");

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending entries, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/noc_rr_lock_arb.md
# noc_rr_lock_arb

Parametrised N-requester arbiter for the NoC switch output port, successor to the 4-way round-robin arbiter.
- Selects among requesters by priority level, with round-robin rotation within a level.
- Holds a grant across multi-flit packets via per-requester lock, with an optional lock-length cap to bound starvation.
- Grant is registered; one instance sits in front of each switch output port, driving the crossbar select.

## Interface
Parameters:
- N, 4: number of requesters, ≥2, need not be a power of two.
- NPRI, 2: number of priority levels, ≥1; higher value wins.
- LOCK_MAX, 0: maximum consecutive locked transfers per grant; 0 = unlimited.
- Derived: PW = max(1, clog2(NPRI)), IDW = max(1, clog2(N)).

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  reset, synchronous, active-high
- req  in  N  request per requester
- req_pri  in  N*PW  priority of requester i in bits [i*PW +: PW]; values ≥NPRI treated as NPRI-1
- lock  in  N  requester i keeps the grant after its current transfer
- out_ready  in  1  downstream accepts the granted transfer this cycle
- grant  out  N  registered one-hot grant
- grant_valid  out  1  grant != 0
- grant_id  out  IDW  index of the granted requester; 0 when not valid

## Operation
- States: IDLE (no grant), GRANT (grant[g] set). Pointer `ptr` (IDW bits) is the round-robin start index.
- Arbitration function:
  - Candidate set = active req bits at the highest req_pri level present.
  - Winner = first candidate at index ptr, ptr+1, … modulo N. Wrap uses explicit compare against N-1, not bit overflow.
- IDLE:
  - If any req: latch winner into grant, grant_id, grant_valid=1 → GRANT.
  - Else stay in IDLE.
- GRANT, transfer defined as req[g] & out_ready:
  - Transfer with lock[g]=1 and cap not reached: keep g and increment lock_cnt.
  - Transfer with lock[g]=0, or lock_cnt == LOCK_MAX-1 when LOCK_MAX≠0: release.
    - ptr ← (g+1) mod N.
    - lock_cnt ← 0.
    - Re-arbitrate in the same cycle with the updated ptr, excluding g only if g is forced out by the cap.
    - If there is a winner, grant it next cycle; else → IDLE.
  - req[g]=0 (withdrawn): release as above, regardless of lock.
  - req[g]=1, out_ready=0: hold grant unchanged. No preemption, even by higher priority.
- Lock is sampled only on transfer cycles; lock on a non-granted requester has no effect.
- Forced release by the cap: g loses that arbitration round; it may win later rounds normally.

## Timing
- Reset values: grant=0, grant_valid=0, grant_id=0, ptr=0, lock_cnt=0, state=IDLE.
- Reset takes effect on the next edge, including mid-lock and mid-stall.
- Latency: req sampled at edge t (IDLE) → grant visible after edge t.
- Back-to-back: releasing transfer at edge t → next grant visible after edge t. No bubble.
- grant, grant_valid and grant_id change only on clock edges and are mutually consistent every cycle.
- Simultaneous events:
  - Release and a new higher-priority request in the same cycle: the new request is included in arbitration.
  - Withdraw and out_ready in the same cycle: treated as withdraw; no transfer.
- lock_cnt width = max(1, clog2(LOCK_MAX+1)); unused when LOCK_MAX=0.

## Structure
- Package noc_arb_pkg:
  - state enum {IDLE, GRANT}.
  - Helper function for modulo-N increment.
  - Shared IDW/PW width functions.
- Sub-module rr_pick:
  - Purely combinational.
  - Inputs: N-bit candidate mask, ptr.
  - Outputs: found flag, winner index.
  - Implemented as a double-width rotate plus priority encoder.
- The top level contains:
  - Priority-level filter.
  - FSM.
  - ptr, lock_cnt and grant registers.

## Test plan
- N=4, req=1111, all pri 0, out_ready=1, lock=0 → grant_id 0,1,2,3,0 on consecutive cycles, grant_valid stays 1.
- N=4, NPRI=2, req=0011, req_pri1=1, req_pri0=0 → grant_id=1 every cycle while req1 held; req1 drops → grant_id=0 next cycle.
- Lock: req=0011, requester 0 wins, lock0=1 for 3 transfers then 0 → grant_id=0 for 4 transfers, then grant_id=1 the next cycle, ptr=1.
- Stall: grant_id=2, out_ready=0 for 5 cycles while a higher-priority req3 asserts → grant_id stays 2; first ready cycle with lock2=0 → grant_id=3 next cycle.
- LOCK_MAX=2, lock0 held high, req=0101 → two transfers on requester 0, forced release, grant_id=2, ptr=1.
- N=5: requester 4 wins and releases with req=10001 → ptr=0, grant_id=0; reset asserted mid-lock → all outputs 0 and state IDLE after the next edge.
